alu_seq: RTL and testbench

//  Parametrised, handshaked RV32I execute-stage ALU. Supports all RV32I integer ops and flags.

---
 rtl/alu_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// RV32I-style execute ALU with valid/ready handshakes, iterative shifter and a held output register.
// Optional iterative multiplier (op 10) is enabled by defining ALU_MUL_EN.
module alu_seq #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] data_r1,
    input  logic [WIDTH-1:0] data_r2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);
    localparam int SAW = $clog2(WIDTH);
    localparam int CW  = SAW + 1;
    localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_MUL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_t;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             n;
        logic             c;
        logic             v;
    } res_t;

    function automatic res_t flags_of(input logic [WIDTH-1:0] r);
        res_t o;
        o.res = r;
        o.z   = (r == {WIDTH{1'b0}});
        o.n   = r[WIDTH-1];
        o.c   = 1'b0;
        o.v   = 1'b0;
        return o;
    endfunction

    function automatic logic is_shift(input logic [3:0] f);
        return (f == OP_SLL) || (f == OP_SRL) || (f == OP_SRA);
    endfunction

    // Every op that completes in one cycle; shifts only arrive here with a zero amount.
    function automatic res_t single_op(input logic [3:0] f, input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
        res_t         r;
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        r   = flags_of({WIDTH{1'b0}});
        case (f)
            OP_ADD: begin
                r   = flags_of(sum[WIDTH-1:0]);
                r.c = sum[WIDTH];
                r.v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                r   = flags_of(sum[WIDTH-1:0]);
                r.c = sum[WIDTH];
                r.v = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL, OP_SRL, OP_SRA: r = flags_of(a);
            OP_SLT:  r = flags_of({{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))});
            OP_SLTU: r = flags_of({{(WIDTH-1){1'b0}}, (a < b)});
            OP_XOR:  r = flags_of(a ^ b);
            OP_OR:   r = flags_of(a | b);
            OP_AND:  r = flags_of(a & b);
            default: r = flags_of({WIDTH{1'b0}});
        endcase
        return r;
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shv_r, shv_s;
    logic [CW-1:0]    rem_r, rem_s;
    logic [3:0]       op_r, op_s;
    res_t             out_r, out_s;
    logic             out_valid_r, out_valid_s;
    logic             accept_s;
    logic [CW-1:0]    shamt_s;
    logic [CW-1:0]    step_s;
    logic [WIDTH-1:0] shifted_s;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0] mcand_r, mcand_s;
    logic [WIDTH-1:0] mplier_r, mplier_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] partial_s;
`endif

    assign in_ready  = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign shamt_s   = {1'b0, data_r2[SAW-1:0]};
    assign step_s    = (rem_r < STEP_C) ? rem_r : STEP_C;

    assign out_valid = out_valid_r;
    assign ALUResult = out_r.res;
    assign Zero      = out_r.z;
    assign Negative  = out_r.n;
    assign Carry     = out_r.c;
    assign Overflow  = out_r.v;

    // One iteration of the shifter on the working register.
    always_comb begin
        shifted_s = shv_r;
        case (op_r)
            OP_SLL:  shifted_s = shv_r << step_s;
            OP_SRL:  shifted_s = shv_r >> step_s;
            OP_SRA:  shifted_s = $signed(shv_r) >>> step_s;
            default: shifted_s = shv_r;
        endcase
    end

`ifdef ALU_MUL_EN
    assign partial_s = mplier_r[0] ? mcand_r : {WIDTH{1'b0}};
`endif

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_s     = state_r;
        shv_s       = shv_r;
        rem_s       = rem_r;
        op_s        = op_r;
        out_s       = out_r;
        out_valid_s = out_valid_r && !out_ready;
`ifdef ALU_MUL_EN
        acc_s       = acc_r;
        mcand_s     = mcand_r;
        mplier_s    = mplier_r;
        cnt_s       = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_shift(op) && (shamt_s != {CW{1'b0}})) begin
                        state_s = ST_SHIFT;
                        shv_s   = data_r1;
                        rem_s   = shamt_s;
                        op_s    = op;
`ifdef ALU_MUL_EN
                    end else if (op == OP_MUL) begin
                        state_s  = ST_MUL;
                        acc_s    = {WIDTH{1'b0}};
                        mcand_s  = data_r1;
                        mplier_s = data_r2;
                        cnt_s    = CW'(WIDTH - 1);
`endif
                    end else begin
                        out_s       = single_op(op, data_r1, data_r2);
                        out_valid_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shv_s = shifted_s;
                rem_s = rem_r - step_s;
                if (rem_r == step_s) begin
                    out_s       = flags_of(shifted_s);
                    out_valid_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
`ifdef ALU_MUL_EN
            // Shift-add: one multiplier bit consumed per cycle, WIDTH cycles total.
            ST_MUL: begin
                acc_s    = acc_r + partial_s;
                mcand_s  = mcand_r << 1;
                mplier_s = mplier_r >> 1;
                cnt_s    = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                if (cnt_r == {CW{1'b0}}) begin
                    out_s       = flags_of(acc_r + partial_s);
                    out_valid_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_MUL;
                end
            end
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            shv_r       <= {WIDTH{1'b0}};
            rem_r       <= {CW{1'b0}};
            op_r        <= 4'd0;
            out_r.res   <= {WIDTH{1'b0}};
            out_r.z     <= 1'b1;
            out_r.n     <= 1'b0;
            out_r.c     <= 1'b0;
            out_r.v     <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef ALU_MUL_EN
            acc_r       <= {WIDTH{1'b0}};
            mcand_r     <= {WIDTH{1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
`endif
        end else begin
            state_r     <= state_s;
            shv_r       <= shv_s;
            rem_r       <= rem_s;
            op_r        <= op_s;
            out_r       <= out_s;
            out_valid_r <= out_valid_s;
`ifdef ALU_MUL_EN
            acc_r       <= acc_s;
            mcand_r     <= mcand_s;
            mplier_r    <= mplier_s;
            cnt_r       <= cnt_s;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] data_r1;
    logic [31:0] data_r2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero, Negative, Carry, Overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] obs_res;
    int          obs_lat;

    alu_seq #(.WIDTH(32), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .data_r1(data_r1), .data_r2(data_r2), .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .Negative(Negative), .Carry(Carry),
        .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected result, flags {Z,N,C,V} and accept-to-valid latency from the op definitions.
    task automatic model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] fl, output int lat);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              sh;
        logic            c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        sh = int'(b[4:0]);
        c = 1'b0; v = 1'b0; lat = 1; r = 32'h0;
        case (f)
            4'd0: begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; v = (sa + sb) != longint'($signed(r)); end
            4'd1: begin r = a - b; c = (a >= b); v = (sa - sb) != longint'($signed(r)); end
            4'd2: r = a << sh;
            4'd3: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd4: r = (ua < ub) ? 32'd1 : 32'd0;
            4'd5: r = a ^ b;
            4'd6: r = a >> sh;
            4'd7: r = $signed(a) >>> sh;
            4'd8: r = a | b;
            4'd9: r = a & b;
`ifdef ALU_MUL_EN
            4'd10: begin r = a * b; lat = 33; end
`endif
            default: r = 32'h0;
        endcase
        if ((f == 4'd2 || f == 4'd6 || f == 4'd7) && sh != 0) lat = (sh + STEP - 1) / STEP + 1;
        fl = {(r == 32'h0), r[31], c, v};
    endtask

    // Issue one op, wait for its result and compare everything against the model.
    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] er;
        logic [3:0]  ef;
        int          el, lat, busy, w;
        model(f, a, b, er, ef, el);
        @(negedge clk);
        op = f; data_r1 = a; data_r2 = b; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq({tag, "_accept"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        busy = 0;
        while (!out_valid && lat < 200) begin
            if (!in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, lat, el);
        check_eq({tag, "_busy"}, busy, el - 1);
        check_eq({tag, "_res"}, ALUResult, er);
        check_eq({tag, "_flags"}, {Zero, Negative, Carry, Overflow}, ef);
        obs_res = ALUResult;
        obs_lat = lat;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] er, er2, a2, b2;
        logic [3:0]  ef, ef2;
        int          el, stale;
        logic [31:0] q[$];

        rst_n = 1'b0; in_valid = 1'b0; op = 4'd0; data_r1 = 32'h0; data_r2 = 32'h0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_res", ALUResult, 32'h0);
        check_eq("rst_flags", {Zero, Negative, Carry, Overflow}, 4'b1000);
        check_eq("rst_ready", in_ready, 1'b1);

        run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1);
        check_eq("add_ovf_const", {obs_res, Zero, Negative, Carry, Overflow}, {32'h8000_0000, 4'b0101});
        run_op("sub_neg", 4'd1, 32'd5, 32'd7);
        check_eq("sub_neg_const", {obs_res, Zero, Negative, Carry, Overflow}, {32'hFFFF_FFFE, 4'b0100});
        run_op("sub_zero", 4'd1, 32'd7, 32'd7);
        check_eq("sub_zero_const", {obs_res, Zero, Negative, Carry, Overflow}, {32'h0, 4'b1010});
        run_op("sra31", 4'd7, 32'h8000_0000, 32'd31);
        check_eq("sra31_const", {obs_res, 32'(obs_lat)}, {32'hFFFF_FFFF, 32'd32});
        run_op("srl31", 4'd6, 32'h8000_0000, 32'd31);
        check_eq("srl31_const", obs_res, 32'h1);
        run_op("sll0", 4'd2, 32'h1234_5678, 32'd0);
        check_eq("sll0_const", {obs_res, 32'(obs_lat)}, {32'h1234_5678, 32'd1});
        run_op("op10", 4'd10, 32'hFFFF_FFFF, 32'h3);
`ifdef ALU_MUL_EN
        check_eq("mul_const", {obs_res, Negative, 32'(obs_lat)}, {32'hFFFF_FFFD, 1'b1, 32'd33});
`else
        check_eq("op10_const", {obs_res, Zero}, {32'h0, 1'b1});
`endif

        // Backpressure: result held for 5 stalled cycles, a pending op waits, then goes on release.
        model(4'd0, 32'h1111_0000, 32'h0000_2222, er, ef, el);
        a2 = $urandom; b2 = $urandom;
        model(4'd0, a2, b2, er2, ef2, el);
        @(negedge clk);
        out_ready = 1'b0; op = 4'd0; data_r1 = 32'h1111_0000; data_r2 = 32'h0000_2222; in_valid = 1'b1;
        @(negedge clk);
        data_r1 = a2; data_r2 = b2;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", out_valid, 1'b1);
            check_eq("bp_hold", {ALUResult, Zero, Negative, Carry, Overflow}, {er, ef});
            check_eq("bp_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp_next_valid", out_valid, 1'b1);
        check_eq("bp_next", {ALUResult, Zero, Negative, Carry, Overflow}, {er2, ef2});
        @(negedge clk);
        check_eq("bp_drop", out_valid, 1'b0);

        // Ten back-to-back ADDs, one result per cycle.
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) begin
                check_eq("b2b_valid", out_valid, 1'b1);
                check_eq("b2b_res", ALUResult, q.pop_front());
            end
            if (i < 10) begin
                check_eq("b2b_ready", in_ready, 1'b1);
                a2 = pick(); b2 = pick();
                q.push_back(a2 + b2);
                op = 4'd0; data_r1 = a2; data_r2 = b2; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("b2b_end", out_valid, 1'b0);

        // Reset in the middle of a long SRA: nothing from it may appear afterwards.
        op = 4'd7; data_r1 = 32'h8000_0000; data_r2 = 32'd31; in_valid = 1'b1;
        check_eq("mid_accept", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("mid_rst_valid", out_valid, 1'b0);
        check_eq("mid_rst_zero", Zero, 1'b1);
        check_eq("mid_rst_res", ALUResult, 32'h0);
        check_eq("mid_rst_ready", in_ready, 1'b1);
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check_eq("mid_rst_stale", stale, 0);

        for (int i = 0; i < 200; i++) begin
            run_op("rand", 4'($urandom_range(0, 15)), pick(), pick());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
